// File: rtl/dmi_req_arbiter.sv
// Shares the debug module's single DMI register port between a pulsed JTAG requester and a
// valid/ready system requester. Define DMI_ARB_RR_EN for round-robin arbitration instead of fixed JTAG priority.
module dmi_req_arbiter (
    input  logic        core_clk,
    input  logic        core_rst_n,
    input  logic        jtag_reg_en,
    input  logic        jtag_reg_wr_en,
    input  logic [6:0]  jtag_addr,
    input  logic [31:0] jtag_wdata,
    output logic [31:0] jtag_rdata,
    output logic        jtag_overrun,
    input  logic        jtag_overrun_clr,
    input  logic        sys_req_valid,
    output logic        sys_req_ready,
    input  logic        sys_req_wr,
    input  logic [6:0]  sys_req_addr,
    input  logic [31:0] sys_req_wdata,
    output logic        sys_resp_valid,
    output logic [31:0] sys_resp_rdata,
    output logic        dmi_reg_en,
    output logic        dmi_reg_wr_en,
    output logic [6:0]  dmi_reg_addr,
    output logic [31:0] dmi_reg_wdata,
    input  logic [31:0] dmi_reg_rdata,
    output logic        busy
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    state_e      state_q, state_d;

    logic        jpend_q, jpend_d;
    logic        jwr_q, jwr_d;
    logic [6:0]  jaddr_q, jaddr_d;
    logic [31:0] jwdata_q, jwdata_d;
    logic        ovr_q, ovr_d;

    logic        win_jtag_q, win_jtag_d;
    logic        wr_q, wr_d;
    logic [6:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;

    logic [31:0] jrdata_q, jrdata_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;

    logic        idle;
    logic        ready_c;
    logic        grant_sys;
    logic        grant_jtag;

`ifdef DMI_ARB_RR_EN
    logic        last_jtag_q, last_jtag_d;
`endif

    assign idle = (state_q == ST_IDLE);

    // Grant decisions look only at registered state, so ready never depends on sys_req_valid.
`ifdef DMI_ARB_RR_EN
    assign ready_c = idle & (~jpend_q | last_jtag_q);
`else
    assign ready_c = idle & ~jpend_q;
`endif
    assign grant_sys  = ready_c & sys_req_valid;
    assign grant_jtag = idle & jpend_q & ~grant_sys;

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (grant_sys || grant_jtag) state_d = ST_ACCESS;
            ST_ACCESS:  state_d = ST_CAPTURE;
            ST_CAPTURE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        dmi_reg_en    = (state_q == ST_ACCESS);
        dmi_reg_wr_en = (state_q == ST_ACCESS) & wr_q;
        busy          = ~idle | jpend_q;
        sys_req_ready = ready_c & core_rst_n;
    end

    always_comb begin
        jpend_d      = jpend_q;
        jwr_d        = jwr_q;
        jaddr_d      = jaddr_q;
        jwdata_d     = jwdata_q;
        ovr_d        = ovr_q;
        win_jtag_d   = win_jtag_q;
        wr_d         = wr_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        jrdata_d     = jrdata_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = resp_rdata_q;

        // A pulse in the grant cycle refills the slot the granted request is vacating.
        if (jtag_reg_en && (!jpend_q || grant_jtag)) begin
            jpend_d  = 1'b1;
            jwr_d    = jtag_reg_wr_en;
            jaddr_d  = jtag_addr;
            jwdata_d = jtag_wdata;
        end else if (grant_jtag) begin
            jpend_d = 1'b0;
        end

        if (jtag_reg_en && jpend_q && !grant_jtag) begin
            ovr_d = 1'b1;
        end else if (jtag_overrun_clr) begin
            ovr_d = 1'b0;
        end

        if (grant_jtag) begin
            win_jtag_d = 1'b1;
            wr_d       = jwr_q;
            addr_d     = jaddr_q;
            wdata_d    = jwdata_q;
        end else if (grant_sys) begin
            win_jtag_d = 1'b0;
            wr_d       = sys_req_wr;
            addr_d     = sys_req_addr;
            wdata_d    = sys_req_wdata;
        end

        if (state_q == ST_CAPTURE) begin
            if (win_jtag_q) begin
                if (!wr_q) jrdata_d = dmi_reg_rdata;
            end else begin
                resp_valid_d = 1'b1;
                resp_rdata_d = wr_q ? 32'h0 : dmi_reg_rdata;
            end
        end
    end

`ifdef DMI_ARB_RR_EN
    always_comb begin
        last_jtag_d = last_jtag_q;
        if (grant_jtag) begin
            last_jtag_d = 1'b1;
        end else if (grant_sys) begin
            last_jtag_d = 1'b0;
        end
    end

    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            last_jtag_q <= 1'b0;
        end else begin
            last_jtag_q <= last_jtag_d;
        end
    end
`endif

    // Everything clears on reset so an interrupted access leaves no response or read-data trace.
    always_ff @(posedge core_clk or negedge core_rst_n) begin
        if (!core_rst_n) begin
            jpend_q      <= 1'b0;
            jwr_q        <= 1'b0;
            jaddr_q      <= 7'h0;
            jwdata_q     <= 32'h0;
            ovr_q        <= 1'b0;
            win_jtag_q   <= 1'b0;
            wr_q         <= 1'b0;
            addr_q       <= 7'h0;
            wdata_q      <= 32'h0;
            jrdata_q     <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
        end else begin
            jpend_q      <= jpend_d;
            jwr_q        <= jwr_d;
            jaddr_q      <= jaddr_d;
            jwdata_q     <= jwdata_d;
            ovr_q        <= ovr_d;
            win_jtag_q   <= win_jtag_d;
            wr_q         <= wr_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            jrdata_q     <= jrdata_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

    assign jtag_rdata     = jrdata_q;
    assign jtag_overrun   = ovr_q;
    assign sys_resp_valid = resp_valid_q;
    assign sys_resp_rdata = resp_rdata_q;
    assign dmi_reg_addr   = addr_q;
    assign dmi_reg_wdata  = wdata_q;

endmodule

// File: tb/tb_dmi_req_arbiter.sv
// Scoreboard bench for dmi_req_arbiter: expected DMI accesses and system responses are queued
// when stimulus is driven and checked as the DUT produces them.
module tb_dmi_req_arbiter;

    logic        core_clk;
    logic        core_rst_n;
    logic        jtag_reg_en;
    logic        jtag_reg_wr_en;
    logic [6:0]  jtag_addr;
    logic [31:0] jtag_wdata;
    logic [31:0] jtag_rdata;
    logic        jtag_overrun;
    logic        jtag_overrun_clr;
    logic        sys_req_valid;
    logic        sys_req_ready;
    logic        sys_req_wr;
    logic [6:0]  sys_req_addr;
    logic [31:0] sys_req_wdata;
    logic        sys_resp_valid;
    logic [31:0] sys_resp_rdata;
    logic        dmi_reg_en;
    logic        dmi_reg_wr_en;
    logic [6:0]  dmi_reg_addr;
    logic [31:0] dmi_reg_wdata;
    logic [31:0] dmi_reg_rdata;
    logic        busy;

    dmi_req_arbiter dut (
        .core_clk         (core_clk),
        .core_rst_n       (core_rst_n),
        .jtag_reg_en      (jtag_reg_en),
        .jtag_reg_wr_en   (jtag_reg_wr_en),
        .jtag_addr        (jtag_addr),
        .jtag_wdata       (jtag_wdata),
        .jtag_rdata       (jtag_rdata),
        .jtag_overrun     (jtag_overrun),
        .jtag_overrun_clr (jtag_overrun_clr),
        .sys_req_valid    (sys_req_valid),
        .sys_req_ready    (sys_req_ready),
        .sys_req_wr       (sys_req_wr),
        .sys_req_addr     (sys_req_addr),
        .sys_req_wdata    (sys_req_wdata),
        .sys_resp_valid   (sys_resp_valid),
        .sys_resp_rdata   (sys_resp_rdata),
        .dmi_reg_en       (dmi_reg_en),
        .dmi_reg_wr_en    (dmi_reg_wr_en),
        .dmi_reg_addr     (dmi_reg_addr),
        .dmi_reg_wdata    (dmi_reg_wdata),
        .dmi_reg_rdata    (dmi_reg_rdata),
        .busy             (busy)
    );

    typedef struct {
        logic        wr;
        logic [6:0]  addr;
        logic [31:0] wdata;
    } dmi_t;

    dmi_t        dmi_q[$];
    logic [31:0] resp_q[$];
    int          en_cyc_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          resp_cyc = 0;
    logic [31:0] exp_jr = 32'h0;
    logic        en_s = 1'b0;
    logic [6:0]  addr_s = 7'h0;

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    always @(posedge core_clk) cyc <= cyc + 1;

    function automatic logic [31:0] rd_model(input logic [6:0] a);
        return (a == 7'h04) ? 32'hA5A5_0001 : {16'hBEE0, 9'h0, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Debug-module model: read data appears the cycle after the strobe, garbage otherwise.
    always @(negedge core_clk) begin
        en_s   <= dmi_reg_en;
        addr_s <= dmi_reg_addr;
    end
    always @(posedge core_clk) begin
        #1;
        dmi_reg_rdata = en_s ? rd_model(addr_s) : 32'hDEAD_BEEF;
    end

    always @(negedge core_clk) begin
        dmi_t e;
        if (dmi_reg_wr_en && !dmi_reg_en) chk("wr_en_without_en", 1, 0);
        if (dmi_reg_en) begin
            en_cyc_q.push_back(cyc);
            if (dmi_q.size() == 0) begin
                chk("dmi_unexpected", {25'h0, dmi_reg_addr}, 32'hFFFF_FFFF);
            end else begin
                e = dmi_q.pop_front();
                chk("dmi_wr", {31'h0, dmi_reg_wr_en}, {31'h0, e.wr});
                chk("dmi_addr", {25'h0, dmi_reg_addr}, {25'h0, e.addr});
                chk("dmi_wdata", dmi_reg_wdata, e.wdata);
            end
        end
        if (sys_resp_valid) begin
            resp_cyc = cyc;
            if (resp_q.size() == 0) chk("resp_unexpected", sys_resp_rdata, 32'hFFFF_FFFF);
            else chk("resp_rdata", sys_resp_rdata, resp_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic push_dmi(input logic wr, input logic [6:0] a, input logic [31:0] d);
        dmi_t e;
        e.wr = wr;
        e.addr = a;
        e.wdata = d;
        dmi_q.push_back(e);
    endtask

    task automatic sys_drive(input logic wr, input logic [6:0] a, input logic [31:0] d);
        sys_req_valid = 1'b1;
        sys_req_wr    = wr;
        sys_req_addr  = a;
        sys_req_wdata = d;
    endtask

    task automatic jtag_set(input logic wr, input logic [6:0] a, input logic [31:0] d);
        jtag_reg_en    = 1'b1;
        jtag_reg_wr_en = wr;
        jtag_addr      = a;
        jtag_wdata     = d;
    endtask

    task automatic wait_accept();
        for (int i = 0; i < 20; i++) begin
            @(negedge core_clk);
            if (sys_req_ready) begin
                tick();
                sys_req_valid = 1'b0;
                return;
            end
        end
        chk("accept_timeout", 0, 1);
        sys_req_valid = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40; i++) begin
            @(negedge core_clk);
            if (!busy && !sys_resp_valid && dmi_q.size() == 0 && resp_q.size() == 0) return;
        end
        chk("drain_timeout", 0, 1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dmi_en"}, {31'h0, dmi_reg_en}, 0);
        chk({tag, "_dmi_wr_en"}, {31'h0, dmi_reg_wr_en}, 0);
        chk({tag, "_dmi_addr"}, {25'h0, dmi_reg_addr}, 0);
        chk({tag, "_dmi_wdata"}, dmi_reg_wdata, 0);
        chk({tag, "_busy"}, {31'h0, busy}, 0);
        chk({tag, "_ready"}, {31'h0, sys_req_ready}, 0);
        chk({tag, "_resp_valid"}, {31'h0, sys_resp_valid}, 0);
        chk({tag, "_resp_rdata"}, sys_resp_rdata, 0);
        chk({tag, "_jtag_rdata"}, jtag_rdata, 0);
        chk({tag, "_overrun"}, {31'h0, jtag_overrun}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        int nen;
        int fall;
        core_rst_n       = 1'b0;
        jtag_reg_en      = 1'b0;
        jtag_reg_wr_en   = 1'b0;
        jtag_addr        = 7'h0;
        jtag_wdata       = 32'h0;
        jtag_overrun_clr = 1'b0;
        sys_req_valid    = 1'b0;
        sys_req_wr       = 1'b0;
        sys_req_addr     = 7'h0;
        sys_req_wdata    = 32'h0;
        dmi_reg_rdata    = 32'hDEAD_BEEF;

        repeat (3) @(posedge core_clk);
        @(negedge core_clk);
        chk_all_zero("reset");
        tick();
        core_rst_n = 1'b1;
        @(negedge core_clk);
        chk("ready_after_reset", {31'h0, sys_req_ready}, 1);

        // System read of 0x04
        tick();
        t0 = cyc;
        nen = en_cyc_q.size();
        push_dmi(1'b0, 7'h04, 32'h0000_0044);
        resp_q.push_back(rd_model(7'h04));
        sys_drive(1'b0, 7'h04, 32'h0000_0044);
        wait_accept();
        drain();
        chk("sys_rd_en_count", en_cyc_q.size(), nen + 1);
        chk("sys_rd_en_cyc", en_cyc_q[nen], t0 + 1);
        chk("sys_rd_resp_cyc", resp_cyc, t0 + 3);

        // JTAG write of 0x10
        tick();
        t0 = cyc;
        nen = en_cyc_q.size();
        push_dmi(1'b1, 7'h10, 32'h8000_0001);
        jtag_set(1'b1, 7'h10, 32'h8000_0001);
        tick();
        jtag_reg_en = 1'b0;
        @(negedge core_clk);
        chk("jtag_wr_busy_pend", {31'h0, busy}, 1);
        fall = -1;
        for (int i = 0; i < 10; i++) begin
            @(negedge core_clk);
            if (!busy && fall < 0) fall = cyc;
        end
        chk("jtag_wr_busy_fall", fall, t0 + 4);
        chk("jtag_wr_en_cyc", en_cyc_q[nen], t0 + 2);
        chk("jtag_wr_rdata_kept", jtag_rdata, exp_jr);

        // JTAG read of 0x05
        tick();
        t0 = cyc;
        push_dmi(1'b0, 7'h05, 32'h0000_1234);
        jtag_set(1'b0, 7'h05, 32'h0000_1234);
        tick();
        jtag_reg_en = 1'b0;
        do @(negedge core_clk); while (cyc < t0 + 3);
        chk("jtag_rd_before", jtag_rdata, exp_jr);
        @(negedge core_clk);
        exp_jr = rd_model(7'h05);
        chk("jtag_rd_after", jtag_rdata, exp_jr);
        drain();

        // Collision behind an in-flight system write, then a repeat collision
        tick();
        t0 = cyc;
        nen = en_cyc_q.size();
        push_dmi(1'b1, 7'h20, 32'h0BAD_F00D);
        resp_q.push_back(32'h0);
        sys_drive(1'b1, 7'h20, 32'h0BAD_F00D);
        tick();
        sys_drive(1'b0, 7'h06, 32'h0000_0066);
        jtag_set(1'b0, 7'h07, 32'h0000_0077);
        push_dmi(1'b0, 7'h07, 32'h0000_0077);
`ifdef DMI_ARB_RR_EN
        push_dmi(1'b0, 7'h06, 32'h0000_0066);
        push_dmi(1'b0, 7'h08, 32'h0000_0088);
`else
        push_dmi(1'b0, 7'h08, 32'h0000_0088);
        push_dmi(1'b0, 7'h06, 32'h0000_0066);
`endif
        resp_q.push_back(rd_model(7'h06));
        tick();
        jtag_reg_en = 1'b0;
        tick();
        tick();
        jtag_set(1'b0, 7'h08, 32'h0000_0088);
        tick();
        jtag_reg_en = 1'b0;
        wait_accept();
        drain();
        chk("coll_en0", en_cyc_q[nen], t0 + 1);
        chk("coll_en1", en_cyc_q[nen + 1], t0 + 4);
        chk("coll_en2", en_cyc_q[nen + 2], t0 + 7);
        chk("coll_en3", en_cyc_q[nen + 3], t0 + 10);
        exp_jr = rd_model(7'h08);
        chk("coll_jtag_rdata", jtag_rdata, exp_jr);
        chk("coll_no_overrun", {31'h0, jtag_overrun}, 0);

        // Second pulse during a system access is dropped
        tick();
        push_dmi(1'b0, 7'h09, 32'h0000_0099);
        resp_q.push_back(rd_model(7'h09));
        sys_drive(1'b0, 7'h09, 32'h0000_0099);
        tick();
        sys_req_valid = 1'b0;
        push_dmi(1'b0, 7'h0A, 32'h0000_00AA);
        jtag_set(1'b0, 7'h0A, 32'h0000_00AA);
        tick();
        jtag_set(1'b0, 7'h0B, 32'h0000_00BB);
        tick();
        jtag_reg_en = 1'b0;
        @(negedge core_clk);
        chk("overrun_set", {31'h0, jtag_overrun}, 1);
        drain();
        exp_jr = rd_model(7'h0A);
        chk("overrun_dropped_rdata", jtag_rdata, exp_jr);
        tick();
        jtag_overrun_clr = 1'b1;
        tick();
        jtag_overrun_clr = 1'b0;
        @(negedge core_clk);
        chk("overrun_clr", {31'h0, jtag_overrun}, 0);

        // Pulse in the grant cycle reloads without overrun
        tick();
        t0 = cyc;
        nen = en_cyc_q.size();
        push_dmi(1'b0, 7'h14, 32'h0000_0014);
        push_dmi(1'b0, 7'h15, 32'h0000_0015);
        jtag_set(1'b0, 7'h14, 32'h0000_0014);
        tick();
        jtag_set(1'b0, 7'h15, 32'h0000_0015);
        tick();
        jtag_reg_en = 1'b0;
        drain();
        chk("reload_no_overrun", {31'h0, jtag_overrun}, 0);
        chk("reload_en0", en_cyc_q[nen], t0 + 2);
        chk("reload_en1", en_cyc_q[nen + 1], t0 + 5);
        exp_jr = rd_model(7'h15);
        chk("reload_rdata", jtag_rdata, exp_jr);

        // Set and clear in the same cycle: set wins
        tick();
        push_dmi(1'b1, 7'h0D, 32'h0000_00DD);
        resp_q.push_back(32'h0);
        sys_drive(1'b1, 7'h0D, 32'h0000_00DD);
        tick();
        sys_req_valid = 1'b0;
        push_dmi(1'b0, 7'h0E, 32'h0000_00EE);
        jtag_set(1'b0, 7'h0E, 32'h0000_00EE);
        tick();
        jtag_set(1'b0, 7'h0F, 32'h0000_00FF);
        jtag_overrun_clr = 1'b1;
        tick();
        jtag_reg_en = 1'b0;
        jtag_overrun_clr = 1'b0;
        @(negedge core_clk);
        chk("overrun_set_beats_clr", {31'h0, jtag_overrun}, 1);
        drain();
        exp_jr = rd_model(7'h0E);
        chk("setclr_rdata", jtag_rdata, exp_jr);

        // Reset asserted in CAPTURE aborts the access
        tick();
        push_dmi(1'b0, 7'h11, 32'h0000_0011);
        sys_drive(1'b0, 7'h11, 32'h0000_0011);
        tick();
        sys_req_valid = 1'b0;
        tick();
        core_rst_n = 1'b0;
        exp_jr = 32'h0;
        @(negedge core_clk);
        chk_all_zero("midreset");
        @(negedge core_clk);
        chk("midreset_no_resp", {31'h0, sys_resp_valid}, 0);
        tick();
        core_rst_n = 1'b1;
        tick();
        push_dmi(1'b0, 7'h12, 32'h0000_0012);
        resp_q.push_back(rd_model(7'h12));
        sys_drive(1'b0, 7'h12, 32'h0000_0012);
        wait_accept();
        drain();
        chk("post_reset_jtag_rdata", jtag_rdata, exp_jr);

        // System write returns zero read data
        tick();
        push_dmi(1'b1, 7'h13, 32'h0000_CAFE);
        resp_q.push_back(32'h0);
        sys_drive(1'b1, 7'h13, 32'h0000_CAFE);
        wait_accept();
        drain();

        chk("dmi_q_empty", dmi_q.size(), 0);
        chk("resp_q_empty", resp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
